// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup / execute-resolve bundle between the B32P pipeline and the
// branch predictor. The pipeline is the master; branch_predict_unit is the slave.
interface branch_predict_unit_if #(
    parameter int ADDR_W = 32
);
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_pc;
    logic              flush;
    logic              pred_valid;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              rs_valid;
    logic [ADDR_W-1:0] rs_pc;
    logic              rs_is_branch;
    logic              rs_taken;
    logic [ADDR_W-1:0] rs_target;
    logic              rs_pred_taken;
    logic [ADDR_W-1:0] rs_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_addr;
    logic [31:0]       perf_lookups;
    logic [31:0]       perf_mispredicts;

    modport master (
        output lu_valid, lu_pc, flush,
        output rs_valid, rs_pc, rs_is_branch, rs_taken, rs_target,
        output rs_pred_taken, rs_pred_target,
        input  pred_valid, pred_taken, pred_target,
        input  mispredict, redirect_addr, perf_lookups, perf_mispredicts
    );

    modport slave (
        input  lu_valid, lu_pc, flush,
        input  rs_valid, rs_pc, rs_is_branch, rs_taken, rs_target,
        input  rs_pred_taken, rs_pred_target,
        output pred_valid, pred_taken, pred_target,
        output mispredict, redirect_addr, perf_lookups, perf_mispredicts
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: predicts at fetch, resolves and trains at execute.
// Optional saturating performance counters are built when BPU_PERF_COUNTERS_EN is defined.
module branch_predict_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic              r_valid  [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];

    logic              r_pred_valid;
    logic              r_pred_taken;
    logic [ADDR_W-1:0] r_pred_target;
    logic              r_mispredict;
    logic [ADDR_W-1:0] r_redirect_addr;

    logic [IDX_W-1:0]  w_lu_idx;
    logic [TAG_W-1:0]  w_lu_tag;
    logic              w_lu_accept;
    logic              w_lu_hit;
    logic [IDX_W-1:0]  w_rs_idx;
    logic [TAG_W-1:0]  w_rs_tag;
    logic              w_rs_hit;
    logic              w_upd;
    logic              w_mispredict;
    logic [ADDR_W-1:0] w_redirect;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'b01;
            3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'b01;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

    assign w_lu_idx    = bus.lu_pc[IDX_W-1:0];
    assign w_lu_tag    = bus.lu_pc[ADDR_W-1:IDX_W];
    assign w_lu_accept = bus.lu_valid & ~bus.flush;
    assign w_lu_hit    = r_valid[w_lu_idx] & (r_tag[w_lu_idx] == w_lu_tag);

    assign w_rs_idx = bus.rs_pc[IDX_W-1:0];
    assign w_rs_tag = bus.rs_pc[ADDR_W-1:IDX_W];
    assign w_rs_hit = r_valid[w_rs_idx] & (r_tag[w_rs_idx] == w_rs_tag);
    assign w_upd    = bus.rs_valid & bus.rs_is_branch;

    // Non-branches predicted taken also redirect to the fall-through PC.
    assign w_mispredict = bus.rs_valid &
        ((bus.rs_is_branch & bus.rs_taken &
          (~bus.rs_pred_taken | (bus.rs_pred_target != bus.rs_target))) |
         (~bus.rs_taken & bus.rs_pred_taken));
    assign w_redirect = (bus.rs_taken & bus.rs_is_branch) ? bus.rs_target
                                                          : bus.rs_pc + ADDR_W'(1);

    // Valid bits and counters: train on hit, allocate weakly-taken on a taken miss.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b00;
            end
        end else if (w_upd && w_rs_hit) begin
            r_ctr[w_rs_idx] <= sat_ctr(r_ctr[w_rs_idx], bus.rs_taken);
        end else if (w_upd && bus.rs_taken) begin
            r_valid[w_rs_idx] <= 1'b1;
            r_ctr[w_rs_idx]   <= 2'b10;
        end
    end

    // Tag and target arrays need no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (w_upd && bus.rs_taken) begin
            r_tag[w_rs_idx]    <= w_rs_tag;
            r_target[w_rs_idx] <= bus.rs_target;
        end
    end

    // Registered lookup result; reads the pre-update array contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= {ADDR_W{1'b0}};
        end else begin
            r_pred_valid  <= w_lu_accept;
            r_pred_taken  <= w_lu_accept & w_lu_hit & r_ctr[w_lu_idx][1];
            r_pred_target <= (w_lu_accept & w_lu_hit) ? r_target[w_lu_idx] : {ADDR_W{1'b0}};
        end
    end

    // Registered resolve result; redirect address holds between resolves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mispredict    <= 1'b0;
            r_redirect_addr <= {ADDR_W{1'b0}};
        end else begin
            r_mispredict <= w_mispredict;
            if (bus.rs_valid) begin
                r_redirect_addr <= w_redirect;
            end
        end
    end

    assign bus.pred_valid    = r_pred_valid;
    assign bus.pred_taken    = r_pred_taken;
    assign bus.pred_target   = r_pred_target;
    assign bus.mispredict    = r_mispredict;
    assign bus.redirect_addr = r_redirect_addr;

`ifdef BPU_PERF_COUNTERS_EN
    logic [31:0] r_perf_lookups;
    logic [31:0] r_perf_mispredicts;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_lookups     <= 32'h0000_0000;
            r_perf_mispredicts <= 32'h0000_0000;
        end else begin
            if (w_lu_accept && (r_perf_lookups != 32'hFFFF_FFFF)) begin
                r_perf_lookups <= r_perf_lookups + 32'h0000_0001;
            end
            if (w_mispredict && (r_perf_mispredicts != 32'hFFFF_FFFF)) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'h0000_0001;
            end
        end
    end

    assign bus.perf_lookups     = r_perf_lookups;
    assign bus.perf_mispredicts = r_perf_mispredicts;
`else
    assign bus.perf_lookups     = 32'h0000_0000;
    assign bus.perf_mispredicts = 32'h0000_0000;
`endif
endmodule
